// File: rtl/rvmyth_dac_feeder.sv
// rvmyth_dac_feeder
//
// Sits between the RVMyth core's output bus and a DAC. Every change of the
// core output is captured into a small circular FIFO. A programmable pacer
// releases one sample per period to the DAC register. This absorbs bursty
// core writes while the DAC keeps a fixed, settled update rate. A sticky flag
// records any sample that was dropped because the FIFO was full.
//
// Ports
//   clk         PLL output clock; every flop updates on its rising edge
//   reset       synchronous reset, active low (0 = reset)
//   core_out    core output bus being monitored
//   en          1 = capture changes of core_out; 0 = capture frozen
//   rate_div    DAC update period in clk cycles (0 behaves as 1)
//   clr_ovf     clears the overflow flag; a drop on the same edge wins
//   dac_d       registered DAC code; holds its value between updates
//   dac_strobe  one-cycle pulse on the edge that dac_d updates
//   fifo_level  current FIFO occupancy, 0..DEPTH
//   overflow    sticky; set when a captured sample was dropped
module rvmyth_dac_feeder #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int DIV_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         core_out,
    input  logic                     en,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         dac_d,
    output logic                     dac_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Storage and state
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] last_cap_q, last_cap_d;
    logic [DIV_W-1:0] cnt_q,      cnt_d;
    logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [WIDTH-1:0] dac_d_q,    dac_d_d;
    logic             strobe_q,   strobe_d;
    logic             ovf_q,      ovf_d;

    // Control
    logic [PW-1:0]    level;
    logic             tick;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [DIV_W-1:0] reload;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // and the occupancy is a plain subtraction.
    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == PW'(DEPTH));

    // Pacer reload value is period-1; a zero period behaves like period 1.
    assign reload = (rate_div == '0) ? '0 : rate_div - DIV_W'(1);
    assign tick   = (cnt_q == '0);

    assign push   = en && (core_out != last_cap_q);
    assign pop    = tick && (level != '0);
    // When full, a simultaneous pop frees the head slot, so the push still fits.
    assign wr_en  = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        last_cap_d = last_cap_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dac_d_d    = dac_d_q;
        strobe_d   = 1'b0;
        ovf_d      = ovf_q;

        // last_cap tracks the bus even when the sample is dropped, so a
        // full FIFO does not cause a stream of repeated drops for one value.
        if (push) begin
            last_cap_d = core_out;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (tick) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        // Head is read from registered storage, so a sample written on
        // this edge cannot be popped until the following one.
        if (pop) begin
            dac_d_d  = mem_q[rd_ptr_q[AW-1:0]];
            strobe_d = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A drop on the same edge as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_cap_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dac_d_q    <= '0;
            strobe_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            last_cap_q <= last_cap_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dac_d_q    <= dac_d_d;
            strobe_q   <= strobe_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage has no reset; contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= core_out;
        end
    end

    assign dac_d      = dac_d_q;
    assign dac_strobe = strobe_q;
    assign fifo_level = level;
    assign overflow   = ovf_q;

endmodule
